// File: rtl/cond_exec_scheduler.sv
// ID-stage conditional-execution sequencer: tracks in-flight flag writers, owns NZCV, issues or annuls.
// Optional macro COND_FLAG_FWD_EN bypasses EX flags when the single pending writer retires this cycle.
module cond_exec_scheduler #(
   parameter int MAX_PEND = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       id_valid,
   input  logic [3:0] id_cond,
   input  logic       id_set_flags,
   input  logic       pipe_hold,
   input  logic       flush,
   input  logic       ex_flag_wr,
   input  logic [3:0] ex_nzcv,
   output logic       id_stall,
   output logic       id_issue,
   output logic       id_exec,
   output logic [3:0] status,
   output logic [2:0] pend_cnt,
   output logic       err
);

   localparam logic [2:0] MAX_P = 3'(MAX_PEND);

   logic [3:0] status_q, status_d;
   logic [2:0] pend_q, pend_d;
   logic       err_q, err_d;

   logic [3:0] flags;
   logic       fwd, flags_ok, needs_flags, cond_pass, live;
   logic       f_n, f_z, f_c, f_v;

   always_comb begin
      flags = status_q;
      fwd   = 1'b0;
`ifdef COND_FLAG_FWD_EN
      if (ex_flag_wr && (pend_q == 3'd1)) begin
         fwd   = 1'b1;
         flags = ex_nzcv;
      end
`endif
      {f_n, f_z, f_c, f_v} = flags;

      cond_pass = 1'b0;
      unique case (id_cond)
         4'b0000: cond_pass = f_z;
         4'b0001: cond_pass = !f_z;
         4'b0010: cond_pass = f_c;
         4'b0011: cond_pass = !f_c;
         4'b0100: cond_pass = f_n;
         4'b0101: cond_pass = !f_n;
         4'b0110: cond_pass = f_v;
         4'b0111: cond_pass = !f_v;
         4'b1000: cond_pass = f_c && !f_z;
         4'b1001: cond_pass = !f_c || f_z;
         4'b1010: cond_pass = (f_n == f_v);
         4'b1011: cond_pass = (f_n != f_v);
         4'b1100: cond_pass = !f_z && (f_n == f_v);
         4'b1101: cond_pass = f_z || (f_n != f_v);
         4'b1110: cond_pass = 1'b1;
         4'b1111: cond_pass = 1'b0;
         default: cond_pass = 1'b0;
      endcase

      flags_ok    = (pend_q == 3'd0) || fwd;
      needs_flags = (id_cond[3:1] != 3'b111);
      live        = id_valid && !flush && !rst;

      // A full tracker only admits a new executing setter if a slot frees this same cycle.
      id_stall = live && ((needs_flags && !flags_ok) ||
                          (id_set_flags && cond_pass && (pend_q == MAX_P) && !ex_flag_wr) ||
                          pipe_hold);
      id_issue = live && !id_stall;
      id_exec  = id_issue && cond_pass;

      status_d = ex_flag_wr ? ex_nzcv : status_q;
      pend_d   = pend_q;
      err_d    = err_q;
      if (ex_flag_wr) begin
         if (pend_q == 3'd0) err_d  = 1'b1;
         else                pend_d = pend_q - 3'd1;
      end
      if (id_exec && id_set_flags) pend_d = pend_d + 3'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         status_q <= 4'b0000;
         pend_q   <= 3'd0;
         err_q    <= 1'b0;
      end else begin
         status_q <= status_d;
         pend_q   <= pend_d;
         err_q    <= err_d;
      end
   end

   assign status   = status_q;
   assign pend_cnt = pend_q;
   assign err      = err_q;

endmodule

// File: tb/tb_cond_exec_scheduler.sv
module tb_cond_exec_scheduler;

   localparam int MP = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       id_valid = 1'b0;
   logic [3:0] id_cond = 4'b0;
   logic       id_set_flags = 1'b0;
   logic       pipe_hold = 1'b0;
   logic       flush = 1'b0;
   logic       ex_flag_wr = 1'b0;
   logic [3:0] ex_nzcv = 4'b0;
   logic       id_stall, id_issue, id_exec, err;
   logic [3:0] status;
   logic [2:0] pend_cnt;

   cond_exec_scheduler #(.MAX_PEND(MP)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_cond(id_cond),
      .id_set_flags(id_set_flags), .pipe_hold(pipe_hold), .flush(flush),
      .ex_flag_wr(ex_flag_wr), .ex_nzcv(ex_nzcv), .id_stall(id_stall),
      .id_issue(id_issue), .id_exec(id_exec), .status(status),
      .pend_cnt(pend_cnt), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic       stall, issue, exec, err;
      logic [3:0] status;
      logic [2:0] pend;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // Reference state: architectural view only.
   logic [3:0] m_status = 4'b0;
   int         m_pend = 0;
   logic       m_err = 1'b0;

   function automatic logic cond_true(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v;
      {n, z, cf, v} = f;
      case (c)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return cf;
         4'd3:  return !cf;
         4'd4:  return n;
         4'd5:  return !n;
         4'd6:  return v;
         4'd7:  return !v;
         4'd8:  return cf & !z;
         4'd9:  return !cf | z;
         4'd10: return n == v;
         4'd11: return n != v;
         4'd12: return !z & (n == v);
         4'd13: return z | (n != v);
         4'd14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic check(input string name, input int act, input int want, input int c);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, c, act, want);
      end
   endtask

   task automatic step(input logic r, input logic v, input logic [3:0] c, input logic sf,
                       input logic h, input logic fl, input logic wr, input logic [3:0] nz);
      exp_t e;
      logic [3:0] f;
      logic ok, pass, st, is;
      @(posedge clk);
      #2;
      rst = r; id_valid = v; id_cond = c; id_set_flags = sf;
      pipe_hold = h; flush = fl; ex_flag_wr = wr; ex_nzcv = nz;
      cyc++;

      f  = m_status;
      ok = (m_pend == 0);
`ifdef COND_FLAG_FWD_EN
      if (wr && m_pend == 1) begin
         f  = nz;
         ok = 1'b1;
      end
`endif
      pass = cond_true(c, f);
      st = 1'b0;
      is = 1'b0;
      if (!r && v && !fl) begin
         if ((c != 4'd14 && c != 4'd15 && !ok) ||
             (sf && pass && m_pend == MP && !wr) || h)
            st = 1'b1;
         else
            is = 1'b1;
      end
      e.cyc = cyc; e.stall = st; e.issue = is; e.exec = is & pass;
      e.status = m_status; e.pend = 3'(m_pend); e.err = m_err;
      q.push_back(e);

      if (r) begin
         m_status = 4'b0; m_pend = 0; m_err = 1'b0;
      end else begin
         if (wr) begin
            m_status = nz;
            if (m_pend == 0) m_err = 1'b1;
            else m_pend--;
         end
         if (is && pass && sf) m_pend++;
      end
   endtask

   // Monitor: compares whatever the DUT presents each cycle against the queued prediction.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            check("id_stall", int'(id_stall), int'(e.stall), e.cyc);
            check("id_issue", int'(id_issue), int'(e.issue), e.cyc);
            check("id_exec",  int'(id_exec),  int'(e.exec),  e.cyc);
            check("status",   int'(status),   int'(e.status), e.cyc);
            check("pend_cnt", int'(pend_cnt), int'(e.pend),  e.cyc);
            check("err",      int'(err),      int'(e.err),   e.cyc);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached got=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      // Reset with a live EQ in ID, then EQ evaluated against Z=0.
      step(1, 1, 4'd0, 0, 0, 0, 0, 4'd0);
      step(1, 1, 4'd0, 0, 0, 0, 0, 4'd0);
      step(0, 1, 4'd0, 0, 0, 0, 0, 4'd0);
      // Dependent conditional after a SUBS.
      step(0, 1, 4'd14, 1, 0, 0, 0, 4'd0);
      step(0, 1, 4'd0, 0, 0, 0, 1, 4'b0100);
      step(0, 1, 4'd0, 0, 0, 0, 0, 4'd0);
      // Annulled setter with status 0000.
      step(0, 1, 4'd14, 1, 0, 0, 0, 4'd0);
      step(0, 0, 4'd0, 0, 0, 0, 1, 4'b0000);
      step(0, 1, 4'd0, 1, 0, 0, 0, 4'd0);
      step(0, 0, 4'd0, 0, 0, 0, 0, 4'd0);
      // Full counter.
      repeat (3) step(0, 1, 4'd14, 1, 0, 0, 0, 4'd0);
      step(0, 1, 4'd14, 1, 0, 0, 0, 4'd0);
      step(0, 1, 4'd14, 1, 0, 0, 1, 4'b0010);
      repeat (3) step(0, 0, 4'd0, 0, 0, 0, 1, 4'b0000);
      // Flush with concurrent writeback, then hold.
      step(0, 1, 4'd14, 1, 0, 0, 0, 4'd0);
      step(0, 1, 4'd12, 0, 0, 0, 0, 4'd0);
      step(0, 1, 4'd12, 0, 0, 1, 1, 4'b0000);
      step(0, 1, 4'd14, 0, 1, 0, 0, 4'd0);
      // Spurious writeback, sticky err, LT/GE.
      step(0, 0, 4'd0, 0, 0, 0, 1, 4'b1001);
      step(0, 1, 4'd11, 0, 0, 0, 0, 4'd0);
      step(0, 1, 4'd10, 0, 0, 0, 0, 4'd0);
      // Reset mid-stall, GT re-evaluated against 0000.
      step(0, 1, 4'd14, 1, 0, 0, 0, 4'd0);
      step(0, 1, 4'd12, 0, 0, 0, 0, 4'd0);
      step(1, 1, 4'd12, 0, 0, 0, 0, 4'd0);
      step(0, 1, 4'd12, 0, 0, 0, 0, 4'd0);

      for (int i = 0; i < 2000; i++) begin
         logic r, v, sf, h, fl, wr;
         logic [3:0] c, nz;
         r  = ($urandom_range(0, 99) < 2);
         v  = ($urandom_range(0, 99) < 85);
         c  = ($urandom_range(0, 2) == 0) ? 4'd14 : 4'($urandom_range(0, 15));
         sf = ($urandom_range(0, 99) < 50);
         h  = ($urandom_range(0, 99) < 10);
         fl = ($urandom_range(0, 99) < 5);
         wr = (m_pend > 0) ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 3);
         nz = 4'($urandom_range(0, 15));
         step(r, v, c, sf, h, fl, wr, nz);
      end

      @(posedge clk);
      @(negedge clk);
      #1;
      check("scoreboard_drained", q.size(), 0, cyc);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cond_exec_scheduler.md
# cond_exec_scheduler

- Sequences conditional execution in the ID stage and owns the architectural NZCV status register.
- Tracks flag-setting instructions that have issued but not yet written back from EX.
- Stalls any conditional instruction in ID until its flags are resolved, then evaluates the ARM condition field and issues the instruction as either executed or annulled (NOP).
- Sits between the ID-stage decoder and the ID/EX pipeline register, and receives flag writeback from the EX stage.

## Interface
- `MAX_PEND`, default 3: maximum in-flight flag writers; legal range 1–7.
- `clk`  in  1  clock; every register updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_valid`  in  1  ID holds a valid instruction.
- `id_cond`  in  4  condition field of the ID instruction.
- `id_set_flags`  in  1  ID instruction has its S bit set.
- `pipe_hold`  in  1  downstream freeze; no issue this cycle.
- `flush`  in  1  squash the ID instruction; takes priority over everything except `rst`.
- `ex_flag_wr`  in  1  EX writes flags this cycle.
- `ex_nzcv`  in  4  flag values written by EX, ordered {N,Z,C,V}.
- `id_stall`  out  1  hold the PC and IF/ID registers.
- `id_issue`  out  1  the ID instruction advances to ID/EX this cycle.
- `id_exec`  out  1  the issued instruction's condition passed; when 0 with `id_issue`=1, ID/EX loads a NOP.
- `status`  out  4  registered NZCV.
- `pend_cnt`  out  3  number of in-flight flag writers.
- `err`  out  1  sticky protocol error.

## Operation
Condition decode, using flags F:
- 0000 EQ: Z
- 0001 NE: !Z
- 0010 CS: C
- 0011 CC: !C
- 0100 MI: N
- 0101 PL: !N
- 0110 VS: V
- 0111 VC: !V
- 1000 HI: C&!Z
- 1001 LS: !C|Z
- 1010 GE: N==V
- 1011 LT: N!=V
- 1100 GT: !Z&(N==V)
- 1101 LE: Z|(N!=V)
- 1110 AL: 1
- 1111 NV: 0

Flags used:
- F = `status`.
- Exception: when forwarding is enabled (see Configuration), F = `ex_nzcv` if `ex_flag_wr`=1 and `pend_cnt`=1.

Resolution:
- `flags_ok` = (`pend_cnt`=0), or the forwarding case above applies.
- Cond AL and NV never need flags.

Stall conditions (all gated by `id_valid` & !`flush`). `id_stall`=1 if any of:
- cond ∉ {AL, NV} and !`flags_ok`
- `id_set_flags` and the condition would pass and `pend_cnt`=`MAX_PEND` and !`ex_flag_wr`
- `pipe_hold`

Issue and execute:
- `id_issue` = `id_valid` & !`flush` & !`id_stall`.
- `id_exec` = `id_issue` & condition(F).

Pending counter:
- Increments when `id_issue` & `id_exec` & `id_set_flags`.
- Decrements on `ex_flag_wr`.
- Simultaneous increment and decrement leaves it unchanged.
- An annulled flag setter (condition failed) does not increment.

Status register:
- Loads `ex_nzcv` on every `ex_flag_wr`, including when `pend_cnt`=0.

Error:
- `ex_flag_wr` with `pend_cnt`=0: no decrement (the counter does not wrap) and `err` is set.
- `err` clears only on `rst`.

Flush:
- Kills only the ID instruction: `id_issue`=`id_stall`=`id_exec`=0.
- Already-issued writers still complete, and `pend_cnt` is unaffected.

`pipe_hold`:
- Blocks issue.
- Flag writeback, counter decrement and status update continue.

## Timing
- Reset values: `status`=0000, `pend_cnt`=0, `err`=0.
- During reset all combinational outputs are 0, regardless of inputs.
- `id_stall`, `id_issue` and `id_exec` are combinational from current state and current-cycle inputs, with zero latency.
- `status` and `pend_cnt` reflect a writeback on the cycle after `ex_flag_wr`.
- Back-to-back case: flag setter S issues in cycle t, and a dependent conditional D arrives in t+1.
  - If S writes back in t+1: with forwarding, D issues in t+1; without forwarding, D issues in t+2.
- Full counter:
  - `pend_cnt`=`MAX_PEND` with `ex_flag_wr`=1: a new setter may issue, and the count holds.
  - `pend_cnt`=`MAX_PEND` with `ex_flag_wr`=0: a new setter stalls.
- `rst` asserted mid-stall: all state clears on that edge, and the pending instruction is re-evaluated against `status`=0000.

## Configuration
- `COND_FLAG_FWD_EN` defined:
  - EX flags bypass to the condition evaluation when exactly one writer is pending and it writes back this cycle.
- `COND_FLAG_FWD_EN` undefined:
  - F is always `status`.
  - `flags_ok` requires `pend_cnt`=0.
  - A dependent conditional stalls one extra cycle.
- All other behaviour is identical in both builds.

## Test plan
- **Reset.**
  - Stimulus: `rst`=1 for 2 cycles with `id_valid`=1, cond=0000.
  - Response: all outputs 0. After release, EQ issues with `id_exec`=0, since Z=0.
- **Dependent conditional.**
  - Stimulus: issue SUBS (cond=1110, S=1). Next cycle, present cond=0000 with `ex_flag_wr`=1, `ex_nzcv`=0100.
  - Response with forwarding: `id_issue`=1, `id_exec`=1.
  - Response without forwarding: `id_stall`=1 for one cycle, then `id_issue`=1, `id_exec`=1. `status`=0100 either way.
- **Annulled setter.**
  - Stimulus: `status`=0000, present cond=0000, S=1.
  - Response: `id_issue`=1, `id_exec`=0, `pend_cnt` stays 0.
- **Full counter** (`MAX_PEND`=3).
  - Stimulus: issue 3 AL setters with no writeback, then present a 4th.
  - Response: `id_stall`=1. Assert `ex_flag_wr`: the 4th issues the same cycle and `pend_cnt` stays 3.
- **Flush and hold.**
  - Stimulus: `pend_cnt`=1, cond=1100 stalled, assert `flush` together with `ex_flag_wr`.
  - Response: `id_stall`=0, `id_issue`=0, `pend_cnt`→0.
  - Stimulus: `pipe_hold`=1 with an AL instruction.
  - Response: `id_stall`=1, `id_issue`=0.
- **Spurious writeback.**
  - Stimulus: `ex_flag_wr`=1, `ex_nzcv`=1001 with `pend_cnt`=0.
  - Response: `status`=1001, `pend_cnt`=0, `err`=1 and stays 1 until `rst`. LT (1011) then evaluates to 0, and GE (1010) to 1.
